regfile_wb_sched: RTL
=====================

# regfile_wb_sched

Writeback scheduler and load scoreboard for the 32-entry integer register file. It merges two writeback sources onto the register file's single write port: the in-order ALU pipeline (stage 5) and out-of-order load returns from memory. Load returns are buffered in a small FIFO. A per-register busy scoreboard stalls the issue stage on read-after-write and write-after-write hazards against outstanding loads. It sits between the stage-5 result bus, the memory response path and the register file write port.

## Interface
- BUS_DATA_WIDTH, 64, data width of results and register contents
- LQ_DEPTH, 4, load-return FIFO depth; power of two, at least 2

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU result valid this cycle; always accepted, no backpressure
- alu_rd  in  5  ALU destination register
- alu_result  in  BUS_DATA_WIDTH  ALU result
- ld_valid  in  1  load return valid
- ld_ready  out  1  FIFO can accept a load return
- ld_rd  in  5  load destination register
- ld_data  in  BUS_DATA_WIDTH  load data
- issue_valid  in  1  an instruction is attempting issue
- issue_is_load  in  1  the issuing instruction is a load
- issue_rs1, issue_rs2, issue_rd  in  5 each  source and destination register indices
- issue_stall  out  1  hold issue this cycle (combinational)
- rf_wr_en  out  1  register file write enable
- rf_rd  out  5  register file write index
- rf_wdata  out  BUS_DATA_WIDTH  register file write data
- lq_count  out  clog2(LQ_DEPTH)+1  FIFO occupancy

## Operation
- Load FIFO push: fires when ld_valid && ld_ready.
  - A push with ld_rd==0 is accepted but dropped. No entry is created.
- ld_ready = !reset && (lq_count < LQ_DEPTH). The count is the registered value; there is no same-cycle pop bypass.
- Arbitration, evaluated each cycle; ALU has fixed priority:
  - If alu_valid && alu_rd!=0: the ALU write wins and the FIFO holds.
  - Otherwise, if the FIFO is non-empty: pop the head.
  - Otherwise: no write.
- ALU writes to x0 are discarded and do not block a FIFO pop that cycle.
- Simultaneous push and pop: both take effect and lq_count is unchanged.
- Write port outputs rf_wr_en, rf_rd and rf_wdata are registered from the arbitration winner. When there is no winner, rf_wr_en=0 and rf_rd/rf_wdata hold their last values.
- Scoreboard is busy[31:1]. busy[0] is constant 0.
  - issue_stall = issue_valid && (busy[issue_rs1] || busy[issue_rs2] || busy[issue_rd]).
  - Set: busy[issue_rd] is set at the clock edge when issue_valid && !issue_stall && issue_is_load && issue_rd!=0.
  - Clear: busy[rf_rd] is cleared at the clock edge ending a cycle in which rf_wr_en=1 for a FIFO-sourced write. A tag bit is registered alongside the write port to mark the source. ALU-sourced writes never clear busy.
  - If set and clear target the same index in the same cycle, set wins. This cannot arise legally, because issue_rd busy forces a stall.
- Load returns with rd not marked busy are still written. No error is flagged.

## Timing
- Reset, synchronous, while reset=1 and in the first cycle after:
  - rf_wr_en=0, rf_rd=0, rf_wdata=0
  - FIFO empty, lq_count=0
  - busy all 0
  - ld_ready=0 during reset
- Reset mid-operation discards all queued loads and busy bits.
- ALU latency: alu_valid in cycle N gives rf_wr_en=1 in cycle N+1.
- Load latency with no ALU traffic:
  - Pushed in N, popped in N+1, rf_wr_en=1 in N+2.
  - busy cleared at the end of N+2.
  - A dependent instruction issues no earlier than N+3.
- FIFO full: ld_ready deasserts the cycle after the push that fills it. It reasserts the cycle after the first pop.
- Continuous ALU traffic starves the FIFO indefinitely. The ALU pipeline guarantees bubbles; no starvation counter is implemented.
- FIFO pointers are log2(LQ_DEPTH) bits wide and wrap modulo LQ_DEPTH.

## Test plan
- Reset, then ALU write of rd=5, value 0xA5 in cycle 1 → rf_wr_en=1, rf_rd=5, rf_wdata=0xA5 in cycle 2. In the same test, alu_rd=0 → no write.
- Issue a load with rd=7 → busy[7]=1. Issue with rs1=7 → issue_stall=1. Load return for rd=7, 0x1234 in cycle N → write in N+2, and the stall drops in N+3.
- ALU valid every cycle for 6 cycles while 4 loads arrive → all 4 accepted and ld_ready=0 afterwards. Fifth load stalls; loads drain in FIFO order once the ALU idles.
- Same-cycle push and pop at lq_count=2 → count stays 2. Pointer wrap is checked across 10 consecutive loads with data matching in order.
- Load return with rd=0 → accepted, lq_count unchanged, no write. Issue of a load with rd=0 → no busy set.
- Assert reset with 3 queued loads and busy[3,9] set → lq_count=0, busy cleared, no rf_wr_en after reset.

Source files
------------

// File: rtl/regfile_wb_sched_if.sv
// Bundles the ALU result bus, the load-return path, the issue hazard query
// and the register file write port of the writeback scheduler.
interface regfile_wb_sched_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int LQ_DEPTH       = 4
);
  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

  logic                      alu_valid;
  logic [4:0]                alu_rd;
  logic [BUS_DATA_WIDTH-1:0] alu_result;

  logic                      ld_valid;
  logic                      ld_ready;
  logic [4:0]                ld_rd;
  logic [BUS_DATA_WIDTH-1:0] ld_data;

  logic                      issue_valid;
  logic                      issue_is_load;
  logic [4:0]                issue_rs1;
  logic [4:0]                issue_rs2;
  logic [4:0]                issue_rd;
  logic                      issue_stall;

  logic                      rf_wr_en;
  logic [4:0]                rf_rd;
  logic [BUS_DATA_WIDTH-1:0] rf_wdata;
  logic [CNT_W-1:0]          lq_count;

  modport master (
    output alu_valid, alu_rd, alu_result,
    output ld_valid, ld_rd, ld_data,
    output issue_valid, issue_is_load, issue_rs1, issue_rs2, issue_rd,
    input  ld_ready, issue_stall, rf_wr_en, rf_rd, rf_wdata, lq_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  ld_valid, ld_rd, ld_data,
    input  issue_valid, issue_is_load, issue_rs1, issue_rs2, issue_rd,
    output ld_ready, issue_stall, rf_wr_en, rf_rd, rf_wdata, lq_count
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Merges in-order ALU writebacks and buffered load returns onto the single
// register file write port, and tracks outstanding loads for issue hazards.
module regfile_wb_sched #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int LQ_DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_wb_sched_if.slave      bus_if
);
  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [BUS_DATA_WIDTH-1:0] lq_data_q [LQ_DEPTH];
  logic [4:0]                lq_rd_q   [LQ_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;

  logic                      wr_en_q, wr_en_d;
  logic [4:0]                rf_rd_q, rf_rd_d;
  logic [BUS_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      from_ld_q, from_ld_d;

  logic [31:0]               busy_q, busy_d;

  logic ld_ready, alu_win, push, pop, stall, busy_set;

  always_comb begin
    ld_ready = !reset && (count_q < CNT_W'(LQ_DEPTH));
    alu_win  = bus_if.alu_valid && (bus_if.alu_rd != 5'd0);
    // Loads to x0 are acknowledged but never occupy a slot.
    push     = bus_if.ld_valid && ld_ready && (bus_if.ld_rd != 5'd0);
    pop      = !alu_win && (count_q != '0);
    stall    = bus_if.issue_valid && (busy_q[bus_if.issue_rs1] ||
               busy_q[bus_if.issue_rs2] || busy_q[bus_if.issue_rd]);
    busy_set = bus_if.issue_valid && !stall && bus_if.issue_is_load &&
               (bus_if.issue_rd != 5'd0);
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    wr_en_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    wdata_d   = wdata_q;
    from_ld_d = 1'b0;
    if (alu_win) begin
      wr_en_d = 1'b1;
      rf_rd_d = bus_if.alu_rd;
      wdata_d = bus_if.alu_result;
    end else if (pop) begin
      wr_en_d   = 1'b1;
      rf_rd_d   = lq_rd_q[rd_ptr_q];
      wdata_d   = lq_data_q[rd_ptr_q];
      from_ld_d = 1'b1;
    end
  end

  // Clear applied before set so a same-index collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q && from_ld_q) busy_d[rf_rd_q] = 1'b0;
    if (busy_set)             busy_d[bus_if.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      lq_data_q[wr_ptr_q] <= bus_if.ld_data;
      lq_rd_q[wr_ptr_q]   <= bus_if.ld_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      rf_rd_q   <= '0;
      wdata_q   <= '0;
      from_ld_q <= 1'b0;
      busy_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      rf_rd_q   <= rf_rd_d;
      wdata_q   <= wdata_d;
      from_ld_q <= from_ld_d;
      busy_q    <= busy_d;
    end
  end

  assign bus_if.ld_ready    = ld_ready;
  assign bus_if.issue_stall = stall;
  assign bus_if.rf_wr_en    = wr_en_q;
  assign bus_if.rf_rd       = rf_rd_q;
  assign bus_if.rf_wdata    = wdata_q;
  assign bus_if.lq_count    = count_q;
endmodule
